csr_access_unit: RTL and testbench

- CSR bus initiator sitting between the decode/execute stage and the CSR field modules, which are the bus responders.
- Accepts one CSRRW/CSRRS/CSRRC request and performs a side-effect-free read phase, capturing old value and ack.
- Then performs a write phase that drives set/clear masks, and returns old value or an illegal-instruction exception code.
- The exception code drives the trap logic's exception_i input.

---
 rtl/csr_pkg.sv | 12 +
 rtl/csr_wmask_gen.sv | 19 +
 rtl/csr_access_unit.sv | 97 +++++++++
 tb/tb_csr_access_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR op/exception encodings and access-unit state type.
package csr_pkg;
  localparam logic [1:0] CSR_OP_RW = 2'b01;
  localparam logic [1:0] CSR_OP_RS = 2'b10;
  localparam logic [1:0] CSR_OP_RC = 2'b11;
  localparam logic [1:0] EXC_NO = 2'b00;
  localparam logic [1:0] EXC_ILLEGAL = 2'b01;
  localparam logic [1:0] EXC_ECALL = 2'b10;
  localparam logic [1:0] EXC_EBREAK = 2'b11;
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_RESP} csr_state_e;
endpackage

// File: rtl/csr_wmask_gen.sv
// csr_wmask_gen: turns a CSR op and source operand into bus set/clear masks.
module csr_wmask_gen
  import csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] wdata,
  input  logic              src_zero,
  output logic [DATA_W-1:0] set_mask,
  output logic [DATA_W-1:0] clear_mask,
  output logic              write_en
);
  always_comb begin
    write_en = (op == CSR_OP_RW) || ((op == CSR_OP_RS || op == CSR_OP_RC) && !src_zero);
    set_mask = (op == CSR_OP_RW || op == CSR_OP_RS) ? wdata : '0;
    clear_mask = (op == CSR_OP_RW) ? ~wdata : (op == CSR_OP_RC) ? wdata : '0;
  end
endmodule

// File: rtl/csr_access_unit.sv
// csr_access_unit: CSR bus initiator doing a read phase then an optional write phase.
// Define CSR_ACK_WAIT_EN to let the read phase wait up to ACK_TIMEOUT cycles for an ack.
module csr_access_unit
  import csr_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              src_zero_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        exception_o,
  output logic              csr_en_o,
  output logic [ADDR_W-1:0] csr_addr_o,
  output logic [DATA_W-1:0] csr_set_o,
  output logic [DATA_W-1:0] csr_clear_o,
  input  logic              csr_ack_i,
  input  logic [DATA_W-1:0] csr_rdata_i
);
  csr_state_e state, state_nx;
  logic [1:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, set_m, clear_m;
  logic src_zero_q, illegal_q, flush_pend, write_en, read_fail, ro, accept;
  csr_wmask_gen #(.DATA_W(DATA_W)) u_wmask (
    .op(op_q), .wdata(wdata_q), .src_zero(src_zero_q),
    .set_mask(set_m), .clear_mask(clear_m), .write_en(write_en)
  );
`ifdef CSR_ACK_WAIT_EN
  logic [2:0] wait_cnt;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) wait_cnt <= '0;
    else wait_cnt <= (state == ST_READ) ? wait_cnt + 3'd1 : '0;
  assign read_fail = !csr_ack_i && wait_cnt == 3'(ACK_TIMEOUT - 1);
`else
  assign read_fail = !csr_ack_i;
`endif
  assign ro = addr_q[ADDR_W-1 -: 2] == CSR_RO_FIELD;
  assign accept = state == ST_IDLE && req_valid_i && !flush_i;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = !accept ? ST_IDLE : (op_i == 2'b00) ? ST_RESP : ST_READ;
      ST_READ:  state_nx = flush_i ? ST_IDLE : (csr_ack_i && write_en && !ro) ? ST_WRITE : (csr_ack_i || read_fail) ? ST_RESP : ST_READ;
      ST_WRITE: state_nx = ST_RESP;
      default:  state_nx = (flush_i || flush_pend || resp_ready_i) ? ST_IDLE : ST_RESP;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state <= ST_IDLE;
      op_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      src_zero_q <= 1'b0;
      rdata_q <= '0;
      illegal_q <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= op_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
        src_zero_q <= src_zero_i;
        rdata_q <= '0;
        illegal_q <= op_i == 2'b00;
        flush_pend <= 1'b0;
      end
      if (state == ST_READ && csr_ack_i) begin
        rdata_q <= csr_rdata_i;
        illegal_q <= write_en && ro;
      end else if (state == ST_READ && read_fail) illegal_q <= 1'b1;
      // a flush during the write phase is honoured once the write has gone out
      if (state == ST_WRITE) flush_pend <= flush_i;
    end
  always_comb begin
    req_ready_o = state == ST_IDLE;
    csr_en_o = state == ST_READ || state == ST_WRITE;
    csr_addr_o = csr_en_o ? addr_q : '0;
    csr_set_o = (state == ST_WRITE) ? set_m : '0;
    csr_clear_o = (state == ST_WRITE) ? clear_m : '0;
    resp_valid_o = state == ST_RESP && !flush_pend;
    rdata_o = resp_valid_o ? rdata_q : '0;
    exception_o = (resp_valid_o && illegal_q) ? EXC_ILLEGAL : EXC_NO;
  end
endmodule

// File: tb/tb_csr_access_unit.sv
// tb_csr_access_unit: randomized and directed check of csr_access_unit against a transaction-level model.
module tb_csr_access_unit;
  logic clk = 1'b0;
  logic rst_i = 1'b0;
  logic req_valid_i = 1'b0, req_ready_o;
  logic [1:0] op_i = 2'b00;
  logic [11:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic src_zero_i = 1'b0, flush_i = 1'b0, resp_valid_o, resp_ready_i = 1'b0;
  logic [31:0] rdata_o;
  logic [1:0] exception_o;
  logic csr_en_o;
  logic [11:0] csr_addr_o;
  logic [31:0] csr_set_o, csr_clear_o;
  logic csr_ack_i = 1'b0;
  logic [31:0] csr_rdata_i = '0;
`ifdef CSR_ACK_WAIT_EN
  localparam int MAX_READS = 4;
`else
  localparam int MAX_READS = 1;
`endif
  logic [31:0] mem [4096];
  logic e_rr, e_en, e_rv;
  logic [11:0] e_addr;
  logic [31:0] e_set, e_clr, e_rd;
  logic [1:0] e_exc;
  int checks = 0, failures = 0;

  csr_access_unit dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i), .src_zero_i(src_zero_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .rdata_o(rdata_o),
    .exception_o(exception_o), .csr_en_o(csr_en_o), .csr_addr_o(csr_addr_o),
    .csr_set_o(csr_set_o), .csr_clear_o(csr_clear_o), .csr_ack_i(csr_ack_i), .csr_rdata_i(csr_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready_o), 32'(e_rr));
    chk("csr_en", 32'(csr_en_o), 32'(e_en));
    chk("csr_addr", 32'(csr_addr_o), 32'(e_addr));
    chk("csr_set", csr_set_o, e_set);
    chk("csr_clear", csr_clear_o, e_clr);
    chk("resp_valid", 32'(resp_valid_o), 32'(e_rv));
    chk("rdata", rdata_o, e_rd);
    chk("exception", 32'(exception_o), 32'(e_exc));
  end

  task automatic set_exp(input logic rr, input logic en, input logic [11:0] a, input logic [31:0] s,
                         input logic [31:0] c, input logic rv, input logic [31:0] rd, input logic [1:0] exc);
    e_rr = rr; e_en = en; e_addr = a; e_set = s; e_clr = c; e_rv = rv; e_rd = rd; e_exc = exc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void masks(input logic [1:0] op, input logic [31:0] wd, output logic [31:0] s, output logic [31:0] c);
    case (op)
      2'b01: begin s = wd; c = ~wd; end
      2'b10: begin s = wd; c = '0; end
      2'b11: begin s = '0; c = wd; end
      default: begin s = '0; c = '0; end
    endcase
  endfunction

  // lat: read cycle on which the responder acks (-1 never); fl_*: cycle index of a flush (-1 none)
  task automatic txn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd, input logic sz,
                     input int lat, input int fl_rd, input bit fl_wr, input int fl_resp, input int rdy_dly,
                     input bit rst_wr, output logic [31:0] rd, output logic [1:0] exc);
    logic writes, ok, gone, pend;
    logic [31:0] s, c;
    writes = op == 2'b01 || (op != 2'b00 && !sz);
    rd = '0; exc = 2'b00; ok = 0; gone = 0; pend = 0;
    req_valid_i = 1; op_i = op; addr_i = addr; wdata_i = wd; src_zero_i = sz;
    tick();
    req_valid_i = 0; op_i = 2'($urandom); addr_i = 12'($urandom); wdata_i = $urandom; src_zero_i = 1'($urandom);
    if (op == 2'b00) exc = 2'b01;
    else begin
      for (int i = 0; i < MAX_READS && !ok && !gone; i++) begin
        set_exp(0, 1, addr, '0, '0, 0, '0, 2'b00);
        csr_ack_i = i == lat;
        csr_rdata_i = csr_ack_i ? mem[addr] : '0;
        flush_i = i == fl_rd;
        tick();
        gone = flush_i; ok = csr_ack_i;
        csr_ack_i = 0; csr_rdata_i = '0; flush_i = 0;
      end
      if (!gone && !ok) exc = 2'b01;
      else if (!gone) begin
        rd = mem[addr];
        if (writes && addr[11:10] == 2'b11) exc = 2'b01;
        else if (writes) begin
          masks(op, wd, s, c);
          set_exp(0, 1, addr, s, c, 0, '0, 2'b00);
          if (rst_wr) begin
            #2 rst_i = 0;
            #1 set_exp(1, 0, '0, '0, '0, 0, '0, 2'b00);
            @(posedge clk);
            #1 rst_i = 1;
            gone = 1;
          end else begin
            flush_i = fl_wr;
            tick();
            flush_i = 0;
            mem[addr] = (mem[addr] | s) & ~c;
            pend = fl_wr;
          end
        end
      end
    end
    if (!gone) begin
      if (pend) begin
        set_exp(0, 0, '0, '0, '0, 0, '0, 2'b00);
        tick();
      end else begin
        set_exp(0, 0, '0, '0, '0, 1, rd, exc);
        for (int k = 0; k <= rdy_dly; k++) begin
          resp_ready_i = k == rdy_dly;
          flush_i = k == fl_resp;
          tick();
          if (flush_i) break;
        end
        resp_ready_i = 0; flush_i = 0;
      end
    end
    set_exp(1, 0, '0, '0, '0, 0, '0, 2'b00);
  endtask

  initial begin
    logic [31:0] rd, s, c;
    logic [1:0] exc;
    logic [11:0] a;
    logic [1:0] op;
    int lat, fl_rd, fl_resp, rdy;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[12'h342] = 32'h2;
    mem[12'h300] = 32'h88;
    set_exp(1, 0, '0, '0, '0, 0, '0, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_i = 1;
    tick();
    masks(2'b01, 32'h8000000B, s, c);
    chk("model_rw_set", s, 32'h8000000B);
    chk("model_rw_clear", c, 32'h7FFFFFF4);
    txn(2'b01, 12'h342, 32'h8000000B, 0, 0, -1, 0, -1, 0, 0, rd, exc);
    chk("rw_rdata", rd, 32'h2);
    chk("rw_exc", 32'(exc), 32'h0);
    chk("rw_mem", mem[12'h342], 32'h8000000B);
    txn(2'b10, 12'h300, 32'h0, 1, 0, -1, 0, -1, 0, 0, rd, exc);
    chk("rs_zero_rdata", rd, 32'h88);
    txn(2'b11, 12'h300, 32'h08, 0, 0, -1, 0, -1, 1, 0, rd, exc);
    txn(2'b10, 12'h300, 32'h0, 1, 0, -1, 0, -1, 0, 0, rd, exc);
    chk("rc_readback", rd, 32'h80);
    txn(2'b01, 12'hC00, 32'h5, 0, 0, -1, 0, -1, 0, 0, rd, exc);
    chk("ro_exc", 32'(exc), 32'h1);
    txn(2'b01, 12'h7C0, 32'h5, 0, -1, -1, 0, -1, 0, 0, rd, exc);
    chk("unmapped_exc", 32'(exc), 32'h1);
    chk("unmapped_rdata", rd, 32'h0);
    txn(2'b01, 12'h342, 32'h1234, 0, 0, -1, 0, -1, 5, 0, rd, exc);
    txn(2'b10, 12'h342, 32'h1, 0, 0, 0, 0, -1, 0, 0, rd, exc);
    txn(2'b10, 12'h342, 32'h1, 0, 0, -1, 1, -1, 0, 0, rd, exc);
    txn(2'b11, 12'h342, 32'h1, 0, 0, -1, 0, 2, 4, 0, rd, exc);
    txn(2'b00, 12'h342, 32'h1, 0, 0, -1, 0, -1, 2, 0, rd, exc);
    chk("reserved_exc", 32'(exc), 32'h1);
    txn(2'b01, 12'h300, 32'hFFFF, 0, 0, -1, 0, -1, 0, 1, rd, exc);
    req_valid_i = 1; flush_i = 1; op_i = 2'b01; addr_i = 12'h342;
    tick();
    req_valid_i = 0; flush_i = 0;
    tick();
`ifdef CSR_ACK_WAIT_EN
    txn(2'b10, 12'h342, 32'h0, 1, 3, -1, 0, -1, 0, 0, rd, exc);
    chk("wait_ack3_exc", 32'(exc), 32'h0);
    txn(2'b10, 12'h342, 32'h0, 1, -1, -1, 0, -1, 0, 0, rd, exc);
    chk("wait_timeout_exc", 32'(exc), 32'h1);
`endif
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 4))
        0: a = 12'h342;
        1: a = 12'h300;
        2: a = 12'hC00 | 12'($urandom_range(0, 63));
        3: a = 12'h7C0 | 12'($urandom_range(0, 63));
        default: a = 12'($urandom);
      endcase
      op = ($urandom_range(0, 15) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
`ifdef CSR_ACK_WAIT_EN
      lat = int'($urandom_range(0, 5));
`else
      lat = ($urandom_range(0, 7) == 0) ? -1 : 0;
`endif
      if (a[11:6] == 6'h1F) lat = -1;
      rdy = int'($urandom_range(0, 3));
      fl_rd = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, MAX_READS - 1)) : -1;
      fl_resp = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, rdy)) : -1;
      txn(op, a, $urandom, $urandom_range(0, 3) == 0, lat, fl_rd, $urandom_range(0, 19) == 0,
          fl_resp, rdy, $urandom_range(0, 49) == 0, rd, exc);
    end
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
